// File: rtl/aload_sequencer.sv
// Upstream sequencer for a bank of async-load flip-flops: drives the rval bus and a
// registered, glitch-free load strobe, then checks the bank's Q against the loaded word.
module aload_sequencer #(
  parameter int unsigned            WIDTH     = 8,
  parameter int unsigned            SETUP_CYC = 2,
  parameter int unsigned            PULSE_CYC = 2,
  parameter int unsigned            RECOV_CYC = 2,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_value,
  output logic [WIDTH-1:0] load_rval,
  output logic             load_arst,
  input  logic [WIDTH-1:0] ff_q,
  output logic             busy,
  output logic             done,
  output logic             mismatch
);

  localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MAX_CYC = (MAX_SP > RECOV_CYC) ? MAX_SP : RECOV_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  generate
    if (SETUP_CYC < 1 || PULSE_CYC < 1 || RECOV_CYC < 1) begin : g_bad_cyc
      $error("aload_sequencer: SETUP_CYC, PULSE_CYC and RECOV_CYC must all be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    RECOV
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rval;
  logic               r_arst;
  logic               r_done;
  logic               r_mism;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [WIDTH-1:0]   w_rval_nxt;
  logic               w_arst_nxt;
  logic               w_done_nxt;
  logic               w_mism_nxt;
  logic               w_cnt_zero;
  logic               w_ready;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_ready    = (r_state == IDLE);

  // The strobe's next value is decoded here but only ever reaches the pin through r_arst.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rval_nxt  = r_rval;
    w_arst_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_mism_nxt  = r_mism;
    unique case (r_state)
      IDLE: begin
        if (req_valid && w_ready) begin
          w_rval_nxt  = req_value;
          w_cnt_nxt   = CNT_W'(SETUP_CYC - 1);
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = PULSE;
          w_cnt_nxt   = CNT_W'(PULSE_CYC - 1);
          w_arst_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      PULSE: begin
        w_arst_nxt = 1'b1;
        if (w_cnt_zero) begin
          w_state_nxt = RECOV;
          w_cnt_nxt   = CNT_W'(RECOV_CYC - 1);
          w_arst_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      RECOV: begin
        if (w_cnt_zero) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
          w_mism_nxt  = (ff_q != r_rval);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rval  <= RESET_VAL;
      r_arst  <= 1'b0;
      r_done  <= 1'b0;
      r_mism  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rval  <= w_rval_nxt;
      r_arst  <= w_arst_nxt;
      r_done  <= w_done_nxt;
      r_mism  <= w_mism_nxt;
    end
  end

  assign req_ready = w_ready;
  assign busy      = ~w_ready;
  assign load_rval = r_rval;
  assign load_arst = r_arst;
  assign done      = r_done;
  assign mismatch  = r_mism;

endmodule
